// File: rtl/audio_pkg.sv
// Audio types and constants shared between the delay stage and the I2S transmitter.
package audio_pkg;
    localparam int SAMPLE_W    = 16;
    localparam int FRAME_SLOTS = 2 * SAMPLE_W;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/i2s_clkgen.sv
// I2S timing: clk divider, bclk, slot counter and lrclk, plus strobes marking
// the clk edge on which bclk falls and the falling edge that enters slot 1.
module i2s_clkgen
    import audio_pkg::*;
#(
    parameter int CLK_DIV  = 16,
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W
) (
    input  logic clk,
    input  logic rst,
    output logic bclk,
    output logic lrclk,
    output logic fall_strobe,
    output logic load_strobe
);
    localparam int SLOTS  = 2 * SAMPLE_W;
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int SLOT_W = $clog2(SLOTS);

    logic [DIV_W-1:0]  div;
    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] slot_nxt;
    logic              tc;

    assign tc          = (div == DIV_W'(CLK_DIV - 1));
    // Strobes are combinational so the top's registers update on the same
    // clk edge that drives bclk low.
    assign fall_strobe = tc & bclk;
    assign load_strobe = fall_strobe & (slot == '0);
    assign slot_nxt    = (slot == SLOT_W'(SLOTS - 1)) ? '0 : slot + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            div   <= '0;
            bclk  <= 1'b0;
            slot  <= '0;
            lrclk <= 1'b0;
        end else begin
            div <= tc ? '0 : div + 1'b1;
            if (tc)
                bclk <= ~bclk;
            if (fall_strobe) begin
                slot  <= slot_nxt;
                lrclk <= (slot_nxt >= SLOT_W'(SAMPLE_W));
            end
        end
    end
endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-entry pair buffer, valid/ready handshake, frame shift
// register and underflow handling. Define I2S_TX_UNDERFLOW_HOLD_EN to repeat
// the last pair on underflow instead of sending zeros.
module i2s_tx
    import audio_pkg::*;
#(
    parameter int CLK_DIV  = 16,
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] left_in,
    input  logic signed [SAMPLE_W-1:0] right_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       bclk,
    output logic                       lrclk,
    output logic                       sdata,
    output logic                       underflow
);
    localparam int SLOTS = 2 * SAMPLE_W;

    logic             fall_strobe;
    logic             load_strobe;
    logic             accept;
    logic             buf_full;
    logic             buf_full_nxt;
    logic [SLOTS-1:0] buf_q;
    logic [SLOTS-1:0] shreg;
    logic [SLOTS-1:0] load_word;
`ifdef I2S_TX_UNDERFLOW_HOLD_EN
    logic [SLOTS-1:0] last_q;
`endif

    i2s_clkgen #(
        .CLK_DIV  (CLK_DIV),
        .SAMPLE_W (SAMPLE_W)
    ) u_clkgen (
        .clk         (clk),
        .rst         (rst),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .fall_strobe (fall_strobe),
        .load_strobe (load_strobe)
    );

    assign accept = in_valid & in_ready;

    // Load consults buf_full as it stands this cycle, so a pair accepted on
    // the load edge waits for the next frame.
    always_comb begin
        buf_full_nxt = buf_full;
        if (load_strobe && buf_full)
            buf_full_nxt = 1'b0;
        if (accept)
            buf_full_nxt = 1'b1;
    end

    always_comb begin
`ifdef I2S_TX_UNDERFLOW_HOLD_EN
        load_word = buf_full ? buf_q : last_q;
`else
        load_word = buf_full ? buf_q : '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b0;
            buf_full  <= 1'b0;
            buf_q     <= '0;
            shreg     <= '0;
            sdata     <= 1'b0;
            underflow <= 1'b0;
`ifdef I2S_TX_UNDERFLOW_HOLD_EN
            last_q    <= '0;
`endif
        end else begin
            in_ready  <= ~buf_full_nxt;
            buf_full  <= buf_full_nxt;
            underflow <= load_strobe & ~buf_full;
            if (accept)
                buf_q <= {left_in, right_in};
            if (load_strobe) begin
                sdata <= load_word[SLOTS-1];
                shreg <= load_word << 1;
`ifdef I2S_TX_UNDERFLOW_HOLD_EN
                if (buf_full)
                    last_q <= buf_q;
`endif
            end else if (fall_strobe) begin
                sdata <= shreg[SLOTS-1];
                shreg <= shreg << 1;
            end
        end
    end
endmodule
